// File: rtl/lynxTypes.sv
// Shared widths and credit sizing helpers used by the write-credit logic.
package lynxTypes;

    localparam int AXI_DATA_BITS = 512;
    localparam int LEN_BITS      = 28;
    localparam int CRED_MAX_DEF  = 64;

    // Counter must represent 0..cmax inclusive.
    function automatic int cred_cnt_bits(input int cmax);
        return $clog2(cmax + 1);
    endfunction

endpackage

// File: rtl/tlb_credits_wr_mc_rr_arbiter.sv
// Round-robin picker: grants the first requester after the last granted index.
// Combinational grant from current req and registered pointer; pointer moves only on advance.
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant
);

    logic [IW-1:0] ptr;
    logic [IW-1:0] gidx;
    logic          found;
    int            idx;

    always_comb begin
        grant = '0;
        gidx  = ptr;
        found = 1'b0;
        idx   = 0;
        for (int i = 1; i <= N; i++) begin
            idx = (int'(ptr) + i) % N;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                gidx       = IW'(idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= IW'(N - 1);
        end else if (advance && found) begin
            ptr <= gidx;
        end
    end

endmodule

// File: rtl/tlb_credits_wr_mc.sv
// Per-channel beat credits gate write requests into one round-robin merged stream.
// Grant to m_req_valid latency 1; m_req_* held while m_req_ready is low, blocking all grants.
module tlb_credits_wr_mc
    import lynxTypes::*;
#(
    parameter  int N_CHAN    = 4,
    parameter  int DATA_BITS = AXI_DATA_BITS,
    parameter  int CRED_MAX  = CRED_MAX_DEF,
    parameter  int PLD_BITS  = 64,
    localparam int CHAN_BITS = (N_CHAN > 1) ? $clog2(N_CHAN) : 1
) (
    input  logic                         aclk,
    input  logic                         areset,
    input  logic [N_CHAN-1:0]            s_req_valid,
    output logic [N_CHAN-1:0]            s_req_ready,
    input  logic [N_CHAN*LEN_BITS-1:0]   s_req_len,
    input  logic [N_CHAN*PLD_BITS-1:0]   s_req_pld,
    input  logic [N_CHAN-1:0]            wxfer,
    output logic                         m_req_valid,
    input  logic                         m_req_ready,
    output logic [LEN_BITS-1:0]          m_req_len,
    output logic [PLD_BITS-1:0]          m_req_pld,
    output logic [CHAN_BITS-1:0]         m_req_chan,
    output logic [N_CHAN-1:0]            cred_err,
    output logic [N_CHAN-1:0]            cred_ovf
);

    localparam int BB       = DATA_BITS / 8;
    localparam int BB_SH    = $clog2(BB);
    localparam int CNT_BITS = cred_cnt_bits(CRED_MAX);
    localparam logic [CNT_BITS-1:0] CNT_MAX = CNT_BITS'(CRED_MAX);

    logic [N_CHAN-1:0]    oversize;
    logic [N_CHAN-1:0]    arb_req;
    logic [N_CHAN-1:0]    grant;
    logic                 arb_free;
    logic                 fwd;
    logic [CHAN_BITS-1:0] sel_idx;

    // The output slot frees up in the same cycle the consumer takes it.
    assign arb_free    = !areset && (!m_req_valid || m_req_ready);
    assign s_req_ready = grant & {N_CHAN{arb_free}};

    for (genvar c = 0; c < N_CHAN; c++) begin : g_chan
        logic [LEN_BITS-1:0] len_c;
        logic [LEN_BITS-1:0] beats;
        logic [CNT_BITS-1:0] cnt;
        logic [CNT_BITS-1:0] dec;
        logic [CNT_BITS:0]   sum;
        logic                err_q;
        logic                ovf_q;

        assign len_c       = s_req_len[c*LEN_BITS +: LEN_BITS];
        assign beats       = (len_c >> BB_SH) + LEN_BITS'(|(len_c & LEN_BITS'(BB - 1)));
        assign oversize[c] = beats > LEN_BITS'(CRED_MAX);
        // Oversize requests still compete so they can be drained and flagged.
        assign arb_req[c]  = s_req_valid[c] && (oversize[c] || LEN_BITS'(cnt) >= beats);

        // beats <= cnt <= CRED_MAX whenever a forwarded grant happens, so truncation is exact.
        assign dec = (s_req_ready[c] && !oversize[c]) ? beats[CNT_BITS-1:0] : '0;
        assign sum = {1'b0, cnt} - {1'b0, dec} + {{CNT_BITS{1'b0}}, wxfer[c]};

        always_ff @(posedge aclk) begin
            if (areset) begin
                cnt   <= '0;
                err_q <= 1'b0;
                ovf_q <= 1'b0;
            end else begin
                cnt   <= (sum > {1'b0, CNT_MAX}) ? CNT_MAX : sum[CNT_BITS-1:0];
                err_q <= s_req_ready[c] && oversize[c];
                if (wxfer[c] && cnt == CNT_MAX && !s_req_ready[c]) begin
                    ovf_q <= 1'b1;
                end
            end
        end

        assign cred_err[c] = err_q;
        assign cred_ovf[c] = ovf_q;
    end

    rr_arbiter #(
        .N (N_CHAN)
    ) u_rr (
        .clk     (aclk),
        .rst     (areset),
        .req     (arb_req),
        .advance (arb_free),
        .grant   (grant)
    );

    always_comb begin
        sel_idx = '0;
        fwd     = 1'b0;
        for (int c = 0; c < N_CHAN; c++) begin
            if (grant[c]) begin
                sel_idx = CHAN_BITS'(c);
                fwd     = !oversize[c];
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            m_req_valid <= 1'b0;
            m_req_len   <= '0;
            m_req_pld   <= '0;
            m_req_chan  <= '0;
        end else if (arb_free) begin
            m_req_valid <= fwd;
            if (fwd) begin
                m_req_len  <= s_req_len[int'(sel_idx)*LEN_BITS +: LEN_BITS];
                m_req_pld  <= s_req_pld[int'(sel_idx)*PLD_BITS +: PLD_BITS];
                m_req_chan <= sel_idx;
            end
        end
    end

endmodule

// File: tb/tb_tlb_credits_wr_mc.sv
// Scenario bench for the multi-channel write-credit merger; a monitor scores m_req against expectations.
module tb_tlb_credits_wr_mc;
    import lynxTypes::*;

    localparam int N  = 4;
    localparam int PB = 64;

    logic                  aclk = 1'b0;
    logic                  areset;
    logic [N-1:0]          s_req_valid;
    logic [N-1:0]          s_req_ready;
    logic [N*LEN_BITS-1:0] s_req_len;
    logic [N*PB-1:0]       s_req_pld;
    logic [N-1:0]          wxfer;
    logic                  m_req_valid;
    logic                  m_req_ready;
    logic [LEN_BITS-1:0]   m_req_len;
    logic [PB-1:0]         m_req_pld;
    logic [1:0]            m_req_chan;
    logic [N-1:0]          cred_err;
    logic [N-1:0]          cred_ovf;

    typedef struct packed {
        logic [1:0]          chan;
        logic [LEN_BITS-1:0] len;
        logic [PB-1:0]       pld;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    tlb_credits_wr_mc #(
        .N_CHAN    (N),
        .DATA_BITS (512),
        .CRED_MAX  (64),
        .PLD_BITS  (PB)
    ) dut (
        .aclk        (aclk),
        .areset      (areset),
        .s_req_valid (s_req_valid),
        .s_req_ready (s_req_ready),
        .s_req_len   (s_req_len),
        .s_req_pld   (s_req_pld),
        .wxfer       (wxfer),
        .m_req_valid (m_req_valid),
        .m_req_ready (m_req_ready),
        .m_req_len   (m_req_len),
        .m_req_pld   (m_req_pld),
        .m_req_chan  (m_req_chan),
        .cred_err    (cred_err),
        .cred_ovf    (cred_ovf)
    );

    always #5 aclk = ~aclk;

    // Output monitor: every accepted m_req must match the oldest expectation.
    always begin
        exp_t e;
        @(negedge aclk);
        #2;
        if (!areset && m_req_valid && m_req_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL mreq_unexpected chan=%0d len=%0d pld=%h", m_req_chan, m_req_len, m_req_pld);
            end else begin
                e = sb.pop_front();
                if (m_req_chan !== e.chan || m_req_len !== e.len || m_req_pld !== e.pld) begin
                    errors++;
                    $display("FAIL mreq_data got chan=%0d len=%0d pld=%h want chan=%0d len=%0d pld=%h",
                             m_req_chan, m_req_len, m_req_pld, e.chan, e.len, e.pld);
                end
            end
        end
    end

    task automatic tick();
        @(negedge aclk);
    endtask

    task automatic set_req(input int c, input logic [LEN_BITS-1:0] len, input logic [PB-1:0] pld);
        s_req_valid[c]                   = 1'b1;
        s_req_len[c*LEN_BITS +: LEN_BITS] = len;
        s_req_pld[c*PB +: PB]            = pld;
    endtask

    task automatic push(input int c, input logic [LEN_BITS-1:0] len, input logic [PB-1:0] pld);
        exp_t e;
        e.chan = 2'(c);
        e.len  = len;
        e.pld  = pld;
        sb.push_back(e);
    endtask

    task automatic apply_reset();
        tick();
        areset      = 1'b1;
        s_req_valid = '0;
        wxfer       = '0;
        tick();
        tick();
        sb.delete();
        areset = 1'b0;
    endtask

    task automatic test_reset();
        tick();
        areset      = 1'b1;
        m_req_ready = 1'b1;
        wxfer       = '1;
        for (int c = 0; c < N; c++) set_req(c, '0, PB'(c));
        tick();
        tick();
        #1;
        checks++;
        if (s_req_ready !== 4'b0000 || m_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_hs s_req_ready=%b m_req_valid=%b want 0000/0", s_req_ready, m_req_valid);
        end
        checks++;
        if (cred_err !== 4'b0000 || cred_ovf !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags cred_err=%b cred_ovf=%b want 0000/0000", cred_err, cred_ovf);
        end
        tick();
        s_req_valid = '0;
        wxfer       = '0;
        areset      = 1'b0;
    endtask

    task automatic test_credit_wait();
        for (int k = 0; k < 4; k++) begin
            tick();
            wxfer[0] = 1'b1;
            if (k == 0) set_req(0, 28'd256, 64'hAAAA_0000_0000_0001);
            #1;
            checks++;
            if (s_req_ready[0] !== 1'b0) begin
                errors++;
                $display("FAIL credit_wait_%0d ready=%b want 0", k, s_req_ready[0]);
            end
        end
        tick();
        wxfer = '0;
        #1;
        checks++;
        if (s_req_ready !== 4'b0001 || m_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL credit_grant ready=%b mvalid=%b want 0001/0", s_req_ready, m_req_valid);
        end
        push(0, 28'd256, 64'hAAAA_0000_0000_0001);
        tick();
        s_req_valid = '0;
        #1;
        checks++;
        if (m_req_valid !== 1'b1) begin
            errors++;
            $display("FAIL credit_latency mvalid=%b want 1", m_req_valid);
        end
        tick();
        set_req(0, 28'd64, 64'h1);
        #1;
        checks++;
        if (s_req_ready[0] !== 1'b0) begin
            errors++;
            $display("FAIL credit_drained ready=%b want 0", s_req_ready[0]);
        end
        tick();
        s_req_valid = '0;
    endtask

    task automatic test_partial_beat();
        tick();
        wxfer = 4'b0010;
        tick();
        tick();
        wxfer = '0;
        set_req(1, 28'd100, 64'hBBBB_0000_0000_0064);
        #1;
        checks++;
        if (s_req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL partial_grant ready=%b want 0010", s_req_ready);
        end
        push(1, 28'd100, 64'hBBBB_0000_0000_0064);
        tick();
        set_req(1, 28'd0, 64'hCCCC_0000_0000_0000);
        #1;
        checks++;
        if (s_req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL zero_len_grant ready=%b want 0010", s_req_ready);
        end
        push(1, 28'd0, 64'hCCCC_0000_0000_0000);
        tick();
        set_req(1, 28'd1, 64'hDDDD);
        #1;
        checks++;
        if (s_req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL partial_drained ready=%b want 0000", s_req_ready);
        end
        tick();
        s_req_valid = '0;
    endtask

    task automatic test_rr_order();
        logic [N-1:0] exp_rdy [5];
        int           exp_ch  [5];
        exp_rdy = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp_ch  = '{0, 1, 2, 3, 0};
        apply_reset();
        m_req_ready = 1'b1;
        wxfer = '1;
        tick();
        tick();
        wxfer = '0;
        for (int c = 0; c < N; c++) set_req(c, 28'd64, 64'hC0DE_0000 + PB'(c));
        for (int i = 0; i < 5; i++) begin
            if (i > 0) tick();
            #1;
            checks++;
            if (s_req_ready !== exp_rdy[i]) begin
                errors++;
                $display("FAIL rr_order_%0d ready=%b want %b", i, s_req_ready, exp_rdy[i]);
            end
            push(exp_ch[i], 28'd64, 64'hC0DE_0000 + PB'(exp_ch[i]));
        end
        tick();
        s_req_valid = '0;
    endtask

    task automatic test_same_cycle();
        apply_reset();
        wxfer = 4'b0100;
        repeat (4) tick();
        set_req(2, 28'd256, 64'h2222_0000_0000_0100);
        #1;
        checks++;
        if (s_req_ready !== 4'b0100) begin
            errors++;
            $display("FAIL same_cycle_grant ready=%b want 0100", s_req_ready);
        end
        push(2, 28'd256, 64'h2222_0000_0000_0100);
        tick();
        wxfer = '0;
        set_req(2, 28'd64, 64'h2222_0000_0000_0040);
        #1;
        checks++;
        if (s_req_ready !== 4'b0100) begin
            errors++;
            $display("FAIL same_cycle_residual ready=%b want 0100", s_req_ready);
        end
        push(2, 28'd64, 64'h2222_0000_0000_0040);
        tick();
        #1;
        checks++;
        if (s_req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL same_cycle_empty ready=%b want 0000", s_req_ready);
        end
        tick();
        s_req_valid = '0;
    endtask

    task automatic test_ovf();
        apply_reset();
        wxfer = 4'b1000;
        repeat (64) tick();
        #1;
        checks++;
        if (cred_ovf !== 4'b0000) begin
            errors++;
            $display("FAIL ovf_early cred_ovf=%b want 0000", cred_ovf);
        end
        tick();
        wxfer = '0;
        set_req(3, 28'd4096, 64'h3333_0000_0000_1000);
        #1;
        checks++;
        if (cred_ovf !== 4'b1000) begin
            errors++;
            $display("FAIL ovf_set cred_ovf=%b want 1000", cred_ovf);
        end
        checks++;
        if (s_req_ready !== 4'b1000) begin
            errors++;
            $display("FAIL ovf_full_grant ready=%b want 1000", s_req_ready);
        end
        push(3, 28'd4096, 64'h3333_0000_0000_1000);
        tick();
        set_req(3, 28'd64, 64'h3);
        #1;
        checks++;
        if (s_req_ready !== 4'b0000 || cred_ovf !== 4'b1000) begin
            errors++;
            $display("FAIL ovf_sticky ready=%b ovf=%b want 0000/1000", s_req_ready, cred_ovf);
        end
        tick();
        s_req_valid = '0;
    endtask

    task automatic test_oversize_hold();
        tick();
        set_req(0, 28'd8192, 64'hBAD0);
        #1;
        checks++;
        if (s_req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL oversize_accept ready=%b want 0001", s_req_ready);
        end
        tick();
        s_req_valid = '0;
        #1;
        checks++;
        if (cred_err !== 4'b0001 || m_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL oversize_err cred_err=%b mvalid=%b want 0001/0", cred_err, m_req_valid);
        end
        tick();
        wxfer = 4'b0110;
        #1;
        checks++;
        if (cred_err !== 4'b0000) begin
            errors++;
            $display("FAIL oversize_pulse cred_err=%b want 0000", cred_err);
        end
        tick();
        wxfer       = '0;
        m_req_ready = 1'b0;
        set_req(1, 28'd64, 64'h5151_5151);
        set_req(2, 28'd64, 64'h5252_5252);
        #1;
        checks++;
        if (s_req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL hold_first ready=%b want 0010", s_req_ready);
        end
        push(1, 28'd64, 64'h5151_5151);
        for (int i = 0; i < 10; i++) begin
            tick();
            s_req_valid[1] = 1'b0;
            #1;
            checks++;
            if (s_req_ready !== 4'b0000 || m_req_valid !== 1'b1 || m_req_chan !== 2'd1 ||
                m_req_len !== 28'd64 || m_req_pld !== 64'h5151_5151) begin
                errors++;
                $display("FAIL hold_%0d ready=%b v=%b ch=%0d len=%0d pld=%h want 0000/1/1/64/51515151",
                         i, s_req_ready, m_req_valid, m_req_chan, m_req_len, m_req_pld);
            end
        end
        tick();
        areset = 1'b1;
        tick();
        #1;
        checks++;
        if (m_req_valid !== 1'b0 || s_req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL hold_reset mvalid=%b ready=%b want 0/0000", m_req_valid, s_req_ready);
        end
        sb.delete();
        tick();
        areset      = 1'b0;
        m_req_ready = 1'b1;
        for (int c = 0; c < N; c++) set_req(c, 28'd64, PB'(c));
        #1;
        checks++;
        if (s_req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL post_reset_credits ready=%b want 0000", s_req_ready);
        end
        tick();
        for (int c = 0; c < N; c++) set_req(c, 28'd0, PB'(c));
        #1;
        checks++;
        if (s_req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL post_reset_ptr ready=%b want 0001", s_req_ready);
        end
        push(0, 28'd0, PB'(0));
        tick();
        s_req_valid = '0;
    endtask

    initial begin
        areset      = 1'b1;
        s_req_valid = '0;
        s_req_len   = '0;
        s_req_pld   = '0;
        wxfer       = '0;
        m_req_ready = 1'b1;

        test_reset();
        test_credit_wait();
        test_partial_beat();
        test_rr_order();
        test_same_cycle();
        test_ovf();
        test_oversize_hold();

        repeat (4) tick();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain pending=%0d want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tlb_credits_wr_mc.md
TLB_CREDITS_WR_MC -- requirements
Module: tlb_credits_wr_mc

Interface
REQ-001 Parameter N_CHAN, default 4, number of independent write channels (1..16).
REQ-002 Parameter DATA_BITS, default AXI_DATA_BITS, data bus width; beat size BB = DATA_BITS/8 bytes.
REQ-003 Parameter CRED_MAX, default 64, per-channel credit ceiling in beats, equal to write buffer depth.
REQ-004 Parameter PLD_BITS, default 64, opaque request payload forwarded unchanged.
REQ-005 aclk  in  1  sole clock, all logic rising-edge.
REQ-006 areset  in  1  reset, synchronous, active-high.
REQ-007 s_req_valid  in  N_CHAN  per-channel request valid.
REQ-008 s_req_ready  out  N_CHAN  per-channel request accept.
REQ-009 s_req_len  in  N_CHAN x LEN_BITS  request length in bytes.
REQ-010 s_req_pld  in  N_CHAN x PLD_BITS  request payload.
REQ-011 wxfer  in  N_CHAN  one data beat written into the channel buffer this cycle.
REQ-012 m_req_valid, m_req_ready, m_req_len, m_req_pld  out/in/out/out  1/1/LEN_BITS/PLD_BITS  merged request stream.
REQ-013 m_req_chan  out  CHAN_BITS=max(1,clog2(N_CHAN))  source channel of m_req.
REQ-014 cred_err  out  N_CHAN  one-cycle pulse, oversize request rejected.
REQ-015 cred_ovf  out  N_CHAN  sticky, wxfer received while credits at CRED_MAX.

Function
REQ-016 n_beats(c) SHALL be ceil(s_req_len[c]/BB); len 0 gives 0 beats.
REQ-017 Each channel SHALL hold a credit counter cnt[c], width clog2(CRED_MAX+1), range 0..CRED_MAX.
REQ-018 Channel c is eligible when s_req_valid[c] and cnt[c] >= n_beats(c) and n_beats(c) <= CRED_MAX.
REQ-019 One eligible channel per cycle SHALL be granted by round-robin; search starts at last granted channel + 1, wrapping at N_CHAN-1 to 0.
REQ-020 Grant only when the output register is empty or m_req_ready=1 in that cycle; s_req_ready[c]=1 only for the granted channel.
REQ-021 Grant loads output register with len, pld, chan; m_req_valid asserts the next cycle (latency 1); m_req_* stable while m_req_valid and not m_req_ready.
REQ-022 Credit update per cycle: cnt_next = cnt - (grant ? n_beats : 0) + (wxfer ? 1 : 0), saturating at CRED_MAX.
REQ-023 Simultaneous grant and wxfer on one channel SHALL apply both in the same cycle; never underflow.
REQ-024 wxfer with cnt=CRED_MAX and no same-cycle grant: cnt unchanged, cred_ovf[c] set until reset.
REQ-025 n_beats(c) > CRED_MAX: s_req_ready[c]=1 for one cycle when arbiter-free (treated as a grant slot, pointer advances), request not forwarded, cnt unchanged, cred_err[c] pulses next cycle.
REQ-026 Ineligible channels SHALL not block others; a stalled channel never affects another channel's credits.
REQ-027 Arbitration and s_req_ready SHALL be combinational from registered state and current inputs; no combinational path m_req_ready -> m_req_valid.

Reset
REQ-028 While areset=1: cnt=0, output register empty, m_req_valid=0, s_req_ready=0, cred_err=0, cred_ovf=0, RR pointer=N_CHAN-1 (channel 0 first).
REQ-029 Reset mid-transfer SHALL discard the held request and all credits; first cycle after deassertion behaves as post-reset.

Structure
REQ-030 CRED_MAX default and credit-count width function SHALL live in lynxTypes; LEN_BITS, AXI_DATA_BITS reused from it.
REQ-031 Round-robin selection SHALL be a sub-module rr_arbiter (N parameter, req/grant one-hot, advance strobe).

Verification (N_CHAN=4, DATA_BITS=512, BB=64, CRED_MAX=64)
REQ-032 Ch0 len=256, 3 wxfer beats -> no ready; 4th beat -> s_req_ready[0] next cycle, m_req_valid one cycle later, cnt[0]=0.
REQ-033 Ch1 len=100 with 2 credits -> granted (ceil=2), cnt[1]=0; len=0 with 0 credits -> granted immediately.
REQ-034 All 4 channels eligible, len=64, m_req_ready=1 -> m_req_chan order 0,1,2,3,0 consecutive cycles.
REQ-035 Ch2 cnt=4, grant len=256 with wxfer same cycle -> cnt[2]=1; 65 wxfer on idle ch3 -> cnt=64, cred_ovf[3]=1.
REQ-036 Ch0 len=8192 (128 beats) -> accepted, not forwarded, cred_err[0] one pulse; m_req_ready=0 for 10 cycles -> output held stable, other channels not granted; areset mid-hold -> all cnt=0, m_req_valid=0.
